// File: rtl/carbon_boot_init_seq_pkg.sv
// Shared types and constants for the boot-time CSR init sequencer.
// Holds the FSM state encoding, table limits and the default CSR map entries.
package carbon_boot_pkg;

  localparam int unsigned CARBON_BOOT_MAX_ENT = 32;
  localparam int unsigned CARBON_BOOT_MAX_TGT = 8;

  localparam logic [31:0] CARBON_CSR_MODEFLAGS      = 32'h0000_0008;
  localparam logic [31:0] CARBON_CSR_8097_MODEFLAGS = 32'h0000_0108;
  localparam logic [31:0] CARBON_CSR_8097_TIER      = 32'h0000_010C;

  typedef enum logic [2:0] {
    ISSUE,
    WAIT,
    VISSUE,
    VWAIT,
    NEXT,
    RELEASE,
    DONE,
    FAULT
  } seq_state_e;

  typedef struct packed {
    logic [2:0]  tgt;
    logic [31:0] addr;
    logic [31:0] wdata;
  } boot_ent_t;

endpackage

// File: rtl/carbon_boot_init_seq_if.sv
// CSR request/response bundle between the init sequencer (master) and the
// per-target CSR master front-ends (slave); read data is flat, 32 bits per target.
interface carbon_boot_init_seq_if #(
  parameter int unsigned N_TGT = 2
);
  logic [N_TGT-1:0]    csr_start;
  logic                csr_write;
  logic [31:0]         csr_addr;
  logic [31:0]         csr_wdata;
  logic [N_TGT-1:0]    csr_busy;
  logic [N_TGT-1:0]    csr_done;
  logic [N_TGT-1:0]    csr_fault;
  logic [N_TGT*32-1:0] csr_rdata;

  modport master (
    output csr_start, csr_write, csr_addr, csr_wdata,
    input  csr_busy, csr_done, csr_fault, csr_rdata
  );

  modport slave (
    input  csr_start, csr_write, csr_addr, csr_wdata,
    output csr_busy, csr_done, csr_fault, csr_rdata
  );
endinterface

// File: rtl/carbon_boot_init_seq.sv
// Table-driven boot CSR write sequencer with retry, then a single CPU run pulse.
// Optional read-back verification of every write: define CARBON_BOOT_INIT_VERIFY_EN.
module carbon_boot_init_seq
  import carbon_boot_pkg::*;
#(
  parameter int unsigned N_TGT            = 2,
  parameter int unsigned N_ENT            = 3,
  parameter int unsigned ENT_TGT   [N_ENT] = '{0, 1, 1},
  parameter logic [31:0] ENT_ADDR  [N_ENT] = '{CARBON_CSR_MODEFLAGS,
                                               CARBON_CSR_8097_MODEFLAGS,
                                               CARBON_CSR_8097_TIER},
  parameter logic [31:0] ENT_WDATA [N_ENT] = '{32'h0, 32'h0, 32'h0},
  parameter int unsigned MAX_RETRY        = 2,
  parameter bit          RELEASE_ON_FAULT = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   restart,
  carbon_boot_init_seq_if.master csr,
  output logic                   halt_req,
  output logic                   run_pulse,
  output logic                   init_done,
  output logic                   init_fault,
  output logic [4:0]             fault_index
);

  if (N_ENT > CARBON_BOOT_MAX_ENT) begin : g_bad_ent
    $fatal(1, "carbon_boot_init_seq: N_ENT=%0d exceeds %0d", N_ENT, CARBON_BOOT_MAX_ENT);
  end
  if (N_TGT < 1 || N_TGT > CARBON_BOOT_MAX_TGT) begin : g_bad_ntgt
    $fatal(1, "carbon_boot_init_seq: N_TGT=%0d out of range", N_TGT);
  end
  for (genvar i = 0; i < N_ENT; i++) begin : g_chk_tgt
    if (ENT_TGT[i] >= N_TGT) begin : g_bad_tgt
      $fatal(1, "carbon_boot_init_seq: ENT_TGT[%0d]=%0d >= N_TGT", i, ENT_TGT[i]);
    end
  end

  // An empty table goes straight to releasing the CPU.
  localparam seq_state_e START_ST = (N_ENT == 0) ? RELEASE : ISSUE;
  localparam logic [4:0] LAST_ENT = 5'(N_ENT - 1);
  localparam logic [3:0] MAX_R    = 4'(MAX_RETRY);

  function automatic boot_ent_t ent_at(input logic [4:0] idx);
    boot_ent_t e;
    e = '0;
    for (int i = 0; i < int'(N_ENT); i++) begin
      if (idx == 5'(i)) begin
        e.tgt   = 3'(ENT_TGT[i]);
        e.addr  = ENT_ADDR[i];
        e.wdata = ENT_WDATA[i];
      end
    end
    return e;
  endfunction

  seq_state_e       state, state_n;
  logic [4:0]       entry, entry_n;
  logic [3:0]       retry, retry_n;
  logic [N_TGT-1:0] start_q, start_n;
  logic             write_q, write_n;
  logic [31:0]      addr_q, addr_n;
  logic [31:0]      wdata_q, wdata_n;
  logic             halt_n, run_n, done_n, fault_n;
  logic [4:0]       fidx_n;
  logic             attempt_failed;

  boot_ent_t        cur, nxt;
  logic [N_TGT-1:0] tgt_oh;
  logic             sel_busy, sel_done, sel_fault;

  assign cur       = ent_at(entry);
  assign nxt       = ent_at(entry_n);
  assign tgt_oh    = N_TGT'(1) << cur.tgt;
  assign sel_busy  = |(csr.csr_busy  & tgt_oh);
  assign sel_done  = |(csr.csr_done  & tgt_oh);
  assign sel_fault = |(csr.csr_fault & tgt_oh);

`ifdef CARBON_BOOT_INIT_VERIFY_EN
  logic [31:0] sel_rdata;
  logic        unused_bits;
  assign unused_bits = ^{cur.addr, nxt.tgt};

  always_comb begin
    sel_rdata = '0;
    for (int t = 0; t < int'(N_TGT); t++) begin
      if (cur.tgt == 3'(t)) sel_rdata = csr.csr_rdata[32*t +: 32];
    end
  end
`else
  logic unused_bits;
  assign unused_bits = ^{csr.csr_rdata, cur.addr, cur.wdata, nxt.tgt};
`endif

  // NOTE: every variable gets its hold/idle value first so no path can infer a latch.
  always_comb begin
    state_n        = state;
    entry_n        = entry;
    retry_n        = retry;
    start_n        = '0;
    run_n          = 1'b0;
    halt_n         = halt_req;
    done_n         = init_done;
    fault_n        = init_fault;
    fidx_n         = fault_index;
    attempt_failed = 1'b0;

    case (state)
      ISSUE: begin
        if (!sel_busy) begin
          start_n = tgt_oh;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (sel_done) begin
          if (sel_fault) attempt_failed = 1'b1;
`ifdef CARBON_BOOT_INIT_VERIFY_EN
          else           state_n = VISSUE;
`else
          else           state_n = NEXT;
`endif
        end
      end
`ifdef CARBON_BOOT_INIT_VERIFY_EN
      VISSUE: begin
        if (!sel_busy) begin
          start_n = tgt_oh;
          state_n = VWAIT;
        end
      end
      VWAIT: begin
        if (sel_done) begin
          if (sel_fault || sel_rdata != cur.wdata) attempt_failed = 1'b1;
          else                                     state_n = NEXT;
        end
      end
`endif
      NEXT: begin
        retry_n = '0;
        if (entry == LAST_ENT) begin
          state_n = RELEASE;
        end else begin
          entry_n = entry + 5'd1;
          state_n = ISSUE;
        end
      end
      RELEASE: begin
        halt_n  = 1'b0;
        run_n   = 1'b1;
        state_n = DONE;
      end
      DONE, FAULT: begin
        if (state == DONE) done_n = 1'b1;
        if (restart) begin
          state_n = START_ST;
          entry_n = '0;
          retry_n = '0;
          halt_n  = 1'b1;
          done_n  = 1'b0;
          fault_n = 1'b0;
        end
      end
      default: state_n = START_ST;
    endcase

    // A failed attempt always restarts from the write of the same entry.
    if (attempt_failed) begin
      if (retry < MAX_R) begin
        retry_n = retry + 4'd1;
        state_n = ISSUE;
      end else begin
        fidx_n  = entry;
        fault_n = 1'b1;
        state_n = FAULT;
        if (RELEASE_ON_FAULT) begin
          halt_n = 1'b0;
          run_n  = 1'b1;
        end
      end
    end

`ifdef CARBON_BOOT_INIT_VERIFY_EN
    write_n = !(state_n inside {VISSUE, VWAIT});
`else
    write_n = 1'b1;
`endif
    if (state_n inside {ISSUE, WAIT, VISSUE, VWAIT}) begin
      addr_n  = nxt.addr;
      wdata_n = nxt.wdata;
    end else begin
      addr_n  = addr_q;
      wdata_n = wdata_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= START_ST;
      entry       <= '0;
      retry       <= '0;
      start_q     <= '0;
      write_q     <= 1'b1;
      addr_q      <= '0;
      wdata_q     <= '0;
      halt_req    <= 1'b1;
      run_pulse   <= 1'b0;
      init_done   <= 1'b0;
      init_fault  <= 1'b0;
      fault_index <= '0;
    end else begin
      state       <= state_n;
      entry       <= entry_n;
      retry       <= retry_n;
      start_q     <= start_n;
      write_q     <= write_n;
      addr_q      <= addr_n;
      wdata_q     <= wdata_n;
      halt_req    <= halt_n;
      run_pulse   <= run_n;
      init_done   <= done_n;
      init_fault  <= fault_n;
      fault_index <= fidx_n;
    end
  end

  assign csr.csr_start = start_q;
  assign csr.csr_write = write_q;
  assign csr.csr_addr  = addr_q;
  assign csr.csr_wdata = wdata_q;

endmodule

// File: doc/carbon_boot_init_seq.md
Name: carbon_boot_init_seq

Overview:
Table-driven boot-time CSR configuration sequencer. It replaces the per-system ad-hoc init FSMs that drive carbon_csr_master_simple instances. It issues an ordered list of CSR writes, each to one of several CSR master front-ends (CPU, FPU, ...), retries faulted writes, and then releases the CPU debug halt with a single run pulse. It sits in each system top between the CSR master instances and the CPU dbg_if halt_req/run_req.

Parameters:
N_TGT, 2, number of CSR master targets (1..8)
N_ENT, 3, number of table entries (0..32)
ENT_TGT, '{0,1,1}, per-entry target index, int unsigned [N_ENT]
ENT_ADDR, '{CARBON_CSR_MODEFLAGS, CARBON_CSR_8097_MODEFLAGS, CARBON_CSR_8097_TIER}, per-entry CSR address, logic [31:0] [N_ENT]
ENT_WDATA, '{0,0,0}, per-entry write data, logic [31:0] [N_ENT]
MAX_RETRY, 2, extra attempts after a faulted write (0..15)
RELEASE_ON_FAULT, 1'b0, 1 = still release the CPU when the sequence ends in fault

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active-low
restart  in  1  pulse; re-runs the table from DONE or FAULT
csr_start  out  N_TGT  one-hot start pulse to the selected target
csr_write  out  1  1 = write, 0 = read (verify only)
csr_addr  out  32  address for the current entry, shared by all targets
csr_wdata  out  32  write data, shared by all targets
csr_busy  in  N_TGT  target busy
csr_done  in  N_TGT  target done pulse
csr_fault  in  N_TGT  target fault, sampled with done
csr_rdata  in  N_TGT*32  target read data, flat; target t is bits [32t+31:32t]
halt_req  out  1  to dbg_if.halt_req
run_pulse  out  1  to dbg_if.run_req
init_done  out  1  sequence finished and CPU released
init_fault  out  1  sequence aborted
fault_index  out  5  entry index that exhausted its retries

Behaviour:
- Reset values: halt_req=1. csr_start=0, run_pulse=0, init_done=0, init_fault=0, fault_index=0, csr_write=1, csr_addr=0, csr_wdata=0. State=ISSUE, entry=0, retry=0.
- All outputs are registered. csr_addr/csr_wdata reflect ENT_ADDR/ENT_WDATA[entry] while in ISSUE or WAIT.
- ISSUE: when csr_busy[ENT_TGT[entry]]==0, assert csr_start[tgt] for exactly one cycle and go to WAIT. If busy is high, hold in ISSUE; there is no timeout.
- WAIT: only csr_done[tgt] is observed; done/fault pulses from other targets are ignored.
  - done with fault=0: go to NEXT.
  - done with fault=1 and retry<MAX_RETRY: retry++ and return to ISSUE.
  - done with fault=1 and retry==MAX_RETRY: fault_index=entry, go to FAULT.
- NEXT: retry=0. If entry==N_ENT-1, go to RELEASE; otherwise entry++ and go to ISSUE.
- N_ENT==0: the state after reset is RELEASE.
- RELEASE: halt_req=0 and run_pulse=1 for one cycle; init_done=1 from the next cycle onward; state DONE.
- FAULT: init_fault=1. If RELEASE_ON_FAULT, perform the RELEASE action once as well, but init_done stays 0. Otherwise halt_req stays 1.
- Minimum latency with single-cycle targets, N_ENT=3: run_pulse is asserted (1 + 3*(issue+done+next)) cycles after reset.
- restart is honoured only in DONE or FAULT; it is ignored otherwise. On restart: halt_req=1, init_done=0, init_fault=0, entry=0, retry=0, state ISSUE.
- restart and a done pulse in the same cycle: the done pulse wins. restart is not queued.
- Reset mid-operation: any outstanding target transaction is abandoned. The targets share rst_n.
- Elaboration checks: any ENT_TGT>=N_TGT or N_ENT>32 is a $fatal.

Optional Feature:
CARBON_BOOT_INIT_VERIFY_EN
- Defined: each successful write is followed by a read (csr_write=0) of the same address through states VISSUE/VWAIT.
  - A read fault, or rdata!=ENT_WDATA, counts as a failed attempt under the same retry rule; the retry restarts from the write.
- Undefined: no read-back; csr_write is constantly 1 and csr_rdata is unused.

Decomposition:
- carbon_boot_pkg holds:
  - seq_state_e (ISSUE, WAIT, VISSUE, VWAIT, NEXT, RELEASE, DONE, FAULT)
  - CARBON_BOOT_MAX_ENT=32
  - CARBON_BOOT_MAX_TGT=8
  - typedef boot_ent_t {tgt, addr, wdata}
- No sub-module; the FSM is flat. System tops instantiate one carbon_csr_master_simple per target next to it.

Test Plan:
- Default table, single-cycle targets, no faults -> 3 starts in order (tgt0 0x…MODEFLAGS, tgt1, tgt1 TIER=P7), then one run_pulse, halt_req 1->0, init_done=1.
- Target 1 faults the 2nd entry twice, then succeeds (MAX_RETRY=2) -> 3 starts on entry 1, init_done=1, init_fault=0.
- Target 1 faults the 2nd entry 3 times -> init_fault=1, fault_index=1, halt_req stays 1, no run_pulse; repeat with RELEASE_ON_FAULT=1 -> run_pulse once, init_done=0.
- Target 0 busy held 10 cycles, plus a spurious csr_done[1] during WAIT on target 0 -> start delayed until busy drops, spurious done ignored, order preserved.
- rst_n asserted mid-WAIT on entry 1, then restart pulsed after DONE -> full reset values, sequence reruns from entry 0, halt_req re-asserted until the new run_pulse.
- VERIFY_EN: read-back returns 0x1 for TIER -> retry from the write; with 0x1 persisting -> init_fault=1, fault_index=2.
